// File: rtl/z_writer_alu.sv
// Multicycle execution unit producing a Z-register write followed by a read strobe.
// Add/sub/reserved finish in one EXEC cycle; shifts iterate one bit per cycle, multiply uses shift-add.
module z_writer_alu #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [1:0]       z_control,
   output logic [WIDTH-1:0] z_data
);

   localparam int CW = $clog2(MUL_CYCLES + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_SLL = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_SRA = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;

   localparam logic [1:0] ZC_IDLE  = 2'b00;
   localparam logic [1:0] ZC_WRITE = 2'b10;
   localparam logic [1:0] ZC_READ  = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_EXEC  = 2'b01,
      S_WRITE = 2'b10,
      S_READ  = 2'b11
   } state_t;

   state_t            state_r, state_s;
   logic [WIDTH-1:0]  a_r, a_s;
   logic [WIDTH-1:0]  b_r, b_s;
   logic [WIDTH-1:0]  acc_r, acc_s;
   logic [WIDTH-1:0]  result_r, result_s;
   logic [2:0]        op_r, op_s;
   logic [CW-1:0]     cnt_r, cnt_s;
   logic [WIDTH-1:0]  shifted_s;
   logic [WIDTH-1:0]  mul_sum_s;
   logic              busy_r, done_r;
   logic [1:0]        z_control_r;
   logic [WIDTH-1:0]  z_data_r;

   // One-bit shift step of the shift operand for the captured shift kind.
   always_comb begin
      shifted_s = a_r;
      case (op_r)
         OP_SLL:  shifted_s = {a_r[WIDTH-2:0], 1'b0};
         OP_SRL:  shifted_s = {1'b0, a_r[WIDTH-1:1]};
         OP_SRA:  shifted_s = {a_r[WIDTH-1], a_r[WIDTH-1:1]};
         default: shifted_s = a_r;
      endcase
   end

   // Shift-add step: a_r is the shifting multiplicand, b_r the shifting multiplier.
   always_comb begin
      if (b_r[0]) begin
         mul_sum_s = acc_r + a_r;
      end else begin
         mul_sum_s = acc_r;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_s  = state_r;
      a_s      = a_r;
      b_s      = b_r;
      acc_s    = acc_r;
      result_s = result_r;
      op_s     = op_r;
      cnt_s    = cnt_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               a_s     = a;
               b_s     = b;
               op_s    = op;
               acc_s   = {WIDTH{1'b0}};
               state_s = S_EXEC;
               if (op == OP_MUL) begin
                  cnt_s = CW'(MUL_CYCLES);
               end else begin
                  cnt_s = CW'(b[4:0]);
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_EXEC: begin
            case (op_r)
               OP_ADD: begin
                  result_s = a_r + b_r;
                  state_s  = S_WRITE;
               end
               OP_SUB: begin
                  result_s = a_r - b_r;
                  state_s  = S_WRITE;
               end
               OP_SLL, OP_SRL, OP_SRA: begin
                  if (cnt_r == {CW{1'b0}}) begin
                     result_s = a_r;
                     state_s  = S_WRITE;
                  end else begin
                     a_s   = shifted_s;
                     cnt_s = cnt_r - CW'(1);
                     if (cnt_r == CW'(1)) begin
                        result_s = shifted_s;
                        state_s  = S_WRITE;
                     end else begin
                        state_s = S_EXEC;
                     end
                  end
               end
               OP_MUL: begin
                  acc_s = mul_sum_s;
                  a_s   = {a_r[WIDTH-2:0], 1'b0};
                  b_s   = {1'b0, b_r[WIDTH-1:1]};
                  cnt_s = cnt_r - CW'(1);
                  if (cnt_r == CW'(1)) begin
                     result_s = mul_sum_s;
                     state_s  = S_WRITE;
                  end else begin
                     state_s = S_EXEC;
                  end
               end
               default: begin
                  result_s = {WIDTH{1'b0}};
                  state_s  = S_WRITE;
               end
            endcase
         end
         S_WRITE: state_s = S_READ;
         S_READ:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // State, datapath and outputs; outputs are registered from the next state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= S_IDLE;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         acc_r       <= {WIDTH{1'b0}};
         result_r    <= {WIDTH{1'b0}};
         op_r        <= 3'b000;
         cnt_r       <= {CW{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         z_control_r <= ZC_IDLE;
         z_data_r    <= {WIDTH{1'b0}};
      end else begin
         state_r  <= state_s;
         a_r      <= a_s;
         b_r      <= b_s;
         acc_r    <= acc_s;
         result_r <= result_s;
         op_r     <= op_s;
         cnt_r    <= cnt_s;
         busy_r   <= (state_s != S_IDLE);
         done_r   <= (state_s == S_READ);
         case (state_s)
            S_WRITE: z_control_r <= ZC_WRITE;
            S_READ:  z_control_r <= ZC_READ;
            default: z_control_r <= ZC_IDLE;
         endcase
         if (state_s == S_WRITE) begin
            z_data_r <= result_s;
         end else begin
            z_data_r <= z_data_r;
         end
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign z_control = z_control_r;
   assign z_data    = z_data_r;

endmodule

// File: doc/z_writer_alu.md
Name: z_writer_alu

Overview:
- Multicycle execution unit that acts as the producer side of the Z-register interface.
- Accepts one operation at a time, computes a 32-bit result, then drives the Z-register write strobe (z_control=2'b10) with the result. It follows this with the read strobe (z_control=2'b01) so the held value appears on the Z output bus.
- Sits between the control unit (start/op) and the Z register in the multicycle datapath.
- Add/sub complete in one cycle. Shifts and multiply are iterative.

Parameters:
- WIDTH, 32, datapath width of operands, result and z_data.
- MUL_CYCLES, 32, EXEC iterations for multiply; must equal WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  operation: 000 add, 001 sub, 010 sll, 011 srl, 100 sra, 101 mul, 110/111 reserved.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted. Shift amount is b[4:0].
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in READ.
- z_control  output  2  Z-register command: 00 idle, 10 write, 01 read. 11 is never driven.
- z_data  output  WIDTH  result value; valid when z_control=10.

Behaviour:
- Reset:
  - rst low at a rising edge forces state IDLE.
  - Clears the operand registers, result, counter, busy, done, z_control and z_data to 0.
  - Reset mid-operation abandons the operation; no Z write is issued.
- State machine, registered outputs: IDLE -> EXEC -> WRITE -> READ -> IDLE.
- IDLE:
  - busy=0, z_control=00.
  - On start=1: capture a, b and op, load the counter, go to EXEC.
  - start while busy=1 is ignored; the request is not queued.
- EXEC length:
  - add/sub: 1 cycle, result = a±b mod 2^WIDTH, carry discarded.
  - reserved ops: 1 cycle, result = 0.
  - shifts: counter = b[4:0]. One 1-bit shift per cycle while counter>0, and the counter decrements.
  - EXEC length for shifts = max(1, b[4:0]). Shift amount 0 spends 1 cycle and returns a unchanged.
  - sra replicates bit WIDTH-1. srl and sll fill with 0.
  - mul: shift-add over exactly MUL_CYCLES cycles. Result = low WIDTH bits of a*b (unsigned; identical low bits for signed).
  - Transition to WRITE occurs on the edge ending the last EXEC cycle.
- WRITE: exactly 1 cycle, z_control=10, z_data=result.
- READ:
  - Exactly 1 cycle, z_control=01, done=1.
  - z_data holds result; it stays stable until the next WRITE.
- Return to IDLE after READ.
  - Earliest next accept: start high in the first IDLE cycle is accepted. No back-to-back acceptance in READ.
- Latency from the accepting edge to the first cycle of done = EXEC length + 2 cycles.
  - add = 3, mul = 34, shift by n = max(1,n)+2.
- z_control is 00 in IDLE and EXEC. 10 and 01 are never asserted in the same cycle.
- Operand changes on a/b/op after acceptance have no effect.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> busy=0, done=0, z_control=00, z_data=0.
- add: a=5, b=7, op=000 -> z_control=10 with z_data=0x0000000C on cycle 2 after accept; done and z_control=01 on cycle 3.
- sub underflow: a=5, b=7, op=001 -> z_data=0xFFFFFFFE; busy for exactly 3 cycles.
- Shifts:
  - sra a=0x80000000, b=4 -> z_data=0xF8000000, done at cycle 6.
  - sll b=0 -> z_data=a, done at cycle 3.
  - srl a=0x80000000, b=31 -> 0x00000001, done at cycle 33.
- mul: a=7, b=6 -> z_data=42 at WRITE, done at cycle 34. Also a=0xFFFFFFFF, b=0xFFFFFFFF -> z_data=0x00000001.
- Interference: pulse start with new operands during EXEC -> ignored, original result written. Then drop rst during an EXEC of mul -> no z_control=10 ever appears, busy=0 next cycle, and a fresh add afterwards completes normally.
